// File: rtl/acc_ctrl_pkg.sv
// Shared opcodes, FSM states and active-low select encodings for acc_ctrl.
package acc_ctrl_pkg;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_LDA = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_STA = 3'b110;
    localparam logic [2:0] OP_CLR = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_WB     = 3'd3,
        S_STORE  = 3'd4
    } state_e;

    // Select vector bit order is {IOR, IAND, ISUB, IADD}; a 0 bit is active.
    localparam logic [3:0] SEL_NONE = 4'b1111;
    localparam logic [3:0] SEL_ADD  = 4'b1110;
    localparam logic [3:0] SEL_SUB  = 4'b1101;
    localparam logic [3:0] SEL_AND  = 4'b1011;
    localparam logic [3:0] SEL_OR   = 4'b0111;

    // Map an opcode to its ALU select pattern; non-ALU opcodes select nothing.
    function automatic logic [3:0] op_sel(input logic [2:0] op);
        case (op)
            OP_ADD:  return SEL_ADD;
            OP_SUB:  return SEL_SUB;
            OP_AND:  return SEL_AND;
            OP_OR:   return SEL_OR;
            default: return SEL_NONE;
        endcase
    endfunction

    function automatic logic is_alu_op(input logic [2:0] op);
        return op_sel(op) != SEL_NONE;
    endfunction

endpackage

// File: rtl/acc_ctrl_acc_reg.sv
// Accumulator register with load/clear and a registered zero flag.
module acc_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             zero
);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic             zero_q, zero_d;

    // Next value: clear wins over load; zero follows whatever is written.
    always_comb begin
        acc_d  = acc_q;
        zero_d = zero_q;
        if (clr) begin
            acc_d  = '0;
            zero_d = 1'b1;
        end else if (load) begin
            acc_d  = d;
            zero_d = (d == '0);
        end
    end

    // State registers; reset leaves an empty (zero) accumulator.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q  <= '0;
            zero_q <= 1'b1;
        end else begin
            acc_q  <= acc_d;
            zero_q <= zero_d;
        end
    end

    assign q    = acc_q;
    assign zero = zero_q;

endmodule

// File: rtl/acc_ctrl.sv
// Accumulator/sequencer feeding an 8-bit ALU: decodes one instruction at a
// time, drives active-low ALU selects, writes back alu_out, and presents STA
// results on a valid/ready output port.
module acc_ctrl
    import acc_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int OPW   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   opcode,
    input  logic [WIDTH-1:0] operand,
    input  logic [WIDTH-1:0] alu_out,
    output logic [WIDTH-1:0] alu_data,
    output logic [WIDTH-1:0] alu_accum,
    output logic             IADD,
    output logic             ISUB,
    output logic             IAND,
    output logic             IOR,
    output logic             EALU,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             zero,
    output logic             done
);

    state_e           state_q, state_d;
    logic [2:0]       opcode_q, opcode_d;
    logic [WIDTH-1:0] alu_data_q, alu_data_d;
    logic [3:0]       sel_q, sel_d;
    logic             ealu_q, ealu_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             done_q, done_d;

    logic             acc_load, acc_clr;
    logic [WIDTH-1:0] acc_din, acc;
    logic [2:0]       op_in;

    assign op_in = opcode[2:0];

    acc_reg #(.WIDTH(WIDTH)) u_acc (
        .clk  (clk),
        .rst  (rst),
        .load (acc_load),
        .clr  (acc_clr),
        .d    (acc_din),
        .q    (acc),
        .zero (zero)
    );

    // Sequencer next-state and datapath control. Selects are raised at accept
    // so they are already low throughout DECODE and EXEC, and the ALU result
    // is captured on the EXEC->WB edge while the select is still active.
    always_comb begin
        state_d     = state_q;
        opcode_d    = opcode_q;
        alu_data_d  = alu_data_q;
        sel_d       = sel_q;
        ealu_d      = ealu_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        done_d      = 1'b0;
        acc_load    = 1'b0;
        acc_clr     = 1'b0;
        acc_din     = alu_out;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d    = S_DECODE;
                    opcode_d   = op_in;
                    alu_data_d = operand;
                    sel_d      = op_sel(op_in);
                    ealu_d     = is_alu_op(op_in);
                end
            end
            S_DECODE: begin
                if (opcode_q == OP_STA) begin
                    state_d     = S_STORE;
                    out_valid_d = 1'b1;
                    out_data_d  = acc;
                end else if (is_alu_op(opcode_q)) begin
                    state_d = S_EXEC;
                end else begin
                    // NOP, LDA and CLR retire without touching the ALU.
                    state_d  = S_WB;
                    done_d   = 1'b1;
                    acc_load = (opcode_q == OP_LDA);
                    acc_clr  = (opcode_q == OP_CLR);
                    acc_din  = alu_data_q;
                end
            end
            S_EXEC: begin
                state_d  = S_WB;
                done_d   = 1'b1;
                acc_load = 1'b1;
                acc_din  = alu_out;
                sel_d    = SEL_NONE;
                ealu_d   = 1'b0;
            end
            S_WB: begin
                state_d = S_IDLE;
            end
            S_STORE: begin
                if (out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM and registered outputs; async reset aborts any instruction in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            opcode_q    <= OP_NOP;
            alu_data_q  <= '0;
            sel_q       <= SEL_NONE;
            ealu_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            opcode_q    <= opcode_d;
            alu_data_q  <= alu_data_d;
            sel_q       <= sel_d;
            ealu_q      <= ealu_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            done_q      <= done_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign alu_data  = alu_data_q;
    assign alu_accum = acc;
    assign {IOR, IAND, ISUB, IADD} = sel_q;
    assign EALU      = ealu_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    // An STA retires in the cycle its output is taken, not a cycle later.
    assign done      = done_q | (out_valid_q & out_ready);

endmodule
